// File: rtl/winograd_ewmm_output.sv
// Winograd F(2x2,3x3) back end: per-beat elementwise multiply, channel accumulation, then A^T*M*A output transform.
// Result appears 3 edges after the last beat is accepted and holds until out_ready; no beats are accepted outside ACC.
module winograd_ewmm_output #(
  parameter int W    = 10,
  parameter int DW   = 10,
  parameter int ACCW = 28
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [16*DW-1:0]          tile_in,
  input  logic [16*W-1:0]           filt_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [4*(ACCW+4)-1:0]     out_data,
  output logic [7:0]                beat_cnt
);

  localparam int OW = ACCW + 4;
  localparam int PW = DW + W;
  localparam int TW = ACCW + 2;

  localparam logic [2:0] S_ACC   = 3'd0;
  localparam logic [2:0] S_DRAIN = 3'd1;
  localparam logic [2:0] S_XF1   = 3'd2;
  localparam logic [2:0] S_XF2   = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]             state_q, state_d;
  logic signed [PW-1:0]   p_q [16];
  logic signed [PW-1:0]   p_d [16];
  logic                   pv_q, pv_d;
  logic                   pfirst_q, pfirst_d;
  logic                   first_q, first_d;
  logic signed [ACCW-1:0] acc_q [16];
  logic signed [ACCW-1:0] acc_d [16];
  logic signed [TW-1:0]   t_q [8];
  logic signed [TW-1:0]   t_d [8];
  logic [4*OW-1:0]        out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic [7:0]             beat_cnt_q, beat_cnt_d;
  logic                   accept;

  assign in_ready  = (state_q == S_ACC);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign beat_cnt  = beat_cnt_q;

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    pv_d        = accept;
    pfirst_d    = pfirst_q;
    first_d     = first_q;
    acc_d       = acc_q;
    t_d         = t_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    beat_cnt_d  = beat_cnt_q;

    if (accept) begin
      for (int i = 0; i < 16; i++) begin
        p_d[i] = PW'($signed(tile_in[i*DW +: DW])) * PW'($signed(filt_in[i*W +: W]));
      end
      // pfirst travels with the product so the fold one edge later knows to load, not add
      pfirst_d   = first_q;
      first_d    = 1'b0;
      beat_cnt_d = first_q ? 8'd1 : ((beat_cnt_q == 8'd255) ? 8'd255 : beat_cnt_q + 8'd1);
    end

    if (pv_q) begin
      for (int i = 0; i < 16; i++) begin
        acc_d[i] = pfirst_q ? ACCW'(p_q[i]) : acc_q[i] + ACCW'(p_q[i]);
      end
    end

    case (state_q)
      S_ACC: begin
        if (accept && in_last) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_XF1;
      S_XF1: begin
        for (int c = 0; c < 4; c++) begin
          t_d[c]   = TW'(acc_q[c]) + TW'(acc_q[4+c]) + TW'(acc_q[8+c]);
          t_d[4+c] = TW'(acc_q[4+c]) - TW'(acc_q[8+c]) - TW'(acc_q[12+c]);
        end
        state_d = S_XF2;
      end
      S_XF2: begin
        for (int r = 0; r < 2; r++) begin
          out_data_d[(2*r)*OW +: OW]   = OW'(t_q[4*r]) + OW'(t_q[4*r+1]) + OW'(t_q[4*r+2]);
          out_data_d[(2*r+1)*OW +: OW] = OW'(t_q[4*r+1]) - OW'(t_q[4*r+2]) - OW'(t_q[4*r+3]);
        end
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          first_d     = 1'b1;
          state_d     = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_ACC;
      pv_q        <= 1'b0;
      pfirst_q    <= 1'b0;
      first_q     <= 1'b1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      beat_cnt_q  <= '0;
      for (int i = 0; i < 16; i++) begin
        p_q[i]   <= '0;
        acc_q[i] <= '0;
      end
      for (int i = 0; i < 8; i++) t_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pv_q        <= pv_d;
      pfirst_q    <= pfirst_d;
      first_q     <= first_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      beat_cnt_q  <= beat_cnt_d;
      p_q         <= p_d;
      acc_q       <= acc_d;
      t_q         <= t_d;
    end
  end

endmodule

// File: tb/tb_winograd_ewmm_output.sv
// Directed and randomized checks of winograd_ewmm_output against a matrix-form A^T*M*A reference.
module tb_winograd_ewmm_output;
  localparam int W = 10, DW = 10, ACCW = 28, OW = ACCW + 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_last = 1'b0;
  logic [16*DW-1:0]  tile_in = '0;
  logic [16*W-1:0]   filt_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [4*OW-1:0]   out_data;
  logic [7:0]        beat_cnt;

  int total = 0;
  int passed = 0;

  logic [16*DW-1:0] qt[$];
  logic [16*W-1:0]  qf[$];
  longint           exp_y[4];

  winograd_ewmm_output #(.W(W), .DW(DW), .ACCW(ACCW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .tile_in(tile_in), .filt_in(filt_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  function automatic logic [159:0] splat(input int v);
    logic [159:0] r;
    logic [9:0]   e;
    e = 10'(v);
    for (int i = 0; i < 16; i++) r[i*10 +: 10] = e;
    return r;
  endfunction

  function automatic logic [159:0] rnd_vec();
    logic [159:0] r;
    for (int i = 0; i < 16; i++) r[i*10 +: 10] = 10'($urandom);
    return r;
  endfunction

  // Reference: M = sum of elementwise products (mod 2^ACCW), y = AT * M * AT'
  function automatic void model();
    longint m[16];
    longint s;
    logic signed [DW-1:0]   a;
    logic signed [W-1:0]    b;
    logic [63:0]            u;
    logic signed [ACCW-1:0] wr;
    int at[2][4];
    at = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};
    for (int i = 0; i < 16; i++) begin
      s = 0;
      for (int k = 0; k < qt.size(); k++) begin
        a = qt[k][i*DW +: DW];
        b = qf[k][i*W +: W];
        s += longint'(a) * longint'(b);
      end
      u = s;
      wr = u[ACCW-1:0];
      m[i] = longint'(wr);
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            s += longint'(at[i][r]) * m[r*4+c] * longint'(at[j][c]);
        exp_y[i*2+j] = s;
      end
  endfunction

  function automatic longint out_el(input int i);
    logic signed [OW-1:0] v;
    v = out_data[i*OW +: OW];
    return longint'(v);
  endfunction

  task automatic send_and_check(input string tag, input int hold);
    int n, lat;
    logic [4*OW-1:0] saved;
    logic stable;
    n = qt.size();
    model();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      tile_in  = qt[k];
      filt_in  = qf[k];
      in_last  = (k == n - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 3);
    for (int i = 0; i < 4; i++) check($sformatf("%s y%0d", tag, i), out_el(i), exp_y[i]);
    check({tag, " beat_cnt"}, beat_cnt, (n > 255) ? 255 : n);
    if (hold > 0) begin
      saved  = out_data;
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
        in_valid = 1'b1;
        in_last  = 1'($urandom);
        tile_in  = rnd_vec();
        filt_in  = rnd_vec();
        @(negedge clk);
        if (out_data !== saved || in_ready !== 1'b0 || out_valid !== 1'b1 || beat_cnt !== 8'((n > 255) ? 255 : n))
          stable = 1'b0;
      end
      check({tag, " hold stable"}, stable, 1);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid cleared"}, out_valid, 0);
    check({tag, " in_ready back"}, in_ready, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " in_ready"}, in_ready, 1);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " out_data"}, (out_data == '0) ? 0 : 1, 0);
    check({tag, " beat_cnt"}, beat_cnt, 0);
  endtask

  initial begin
    #3;
    check_reset_state("reset");
    @(negedge clk);
    rstn = 1'b1;

    // single all-ones beat
    qt = {}; qf = {};
    qt.push_back(splat(1)); qf.push_back(splat(1));
    send_and_check("ones", 0);
    check("ones y00 const", out_el(0), 9);

    // two beats summing to M=2
    qt = {}; qf = {};
    qt.push_back(splat(2));  qf.push_back(splat(3));
    qt.push_back(splat(-1)); qf.push_back(splat(4));
    send_and_check("two", 0);

    // impulse at index 5, with backpressure
    qt = {}; qf = {};
    qt.push_back(160'(1) << (5*DW)); qf.push_back(splat(1));
    send_and_check("impulse", 5);

    // extreme negative operands
    qt = {}; qf = {};
    qt.push_back(splat(-512)); qf.push_back(splat(-512));
    send_and_check("neg512", 0);
    check("neg512 y00 const", out_el(0), 2359296);

    // reset in the middle of a group
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_last  = 1'b0;
      tile_in  = rnd_vec();
      filt_in  = rnd_vec();
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("midgrp beat_cnt", beat_cnt, 2);
    rstn = 1'b0;
    #2;
    check_reset_state("midgrp reset");
    @(negedge clk);
    rstn = 1'b1;
    qt = {}; qf = {};
    qt.push_back(splat(1)); qf.push_back(splat(1));
    send_and_check("post_reset", 0);

    // randomized groups
    for (int g = 0; g < 8; g++) begin
      int n;
      n = $urandom_range(1, 6);
      qt = {}; qf = {};
      for (int k = 0; k < n; k++) begin
        qt.push_back(rnd_vec());
        qf.push_back(rnd_vec());
      end
      send_and_check($sformatf("rand%0d", g), $urandom_range(0, 3));
    end

    // long group exercising beat_cnt saturation
    qt = {}; qf = {};
    for (int k = 0; k < 260; k++) begin
      qt.push_back(rnd_vec());
      qf.push_back(rnd_vec());
    end
    send_and_check("long", 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/winograd_ewmm_output.md
WINOGRAD_EWMM_OUTPUT -- requirements
Module: winograd_ewmm_output

Interface
REQ-001 SHALL have parameter W, default 10: signed width of each transformed-filter element.
REQ-002 SHALL have parameter DW, default 10: signed width of each transformed input-tile element.
REQ-003 SHALL have parameter ACCW, default 28: signed accumulator width; derived OW = ACCW+4 is the output element width.
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  beat valid.
REQ-007 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready at a clk edge.
REQ-008 SHALL have port in_last  input  1  marks the final channel beat of a group.
REQ-009 SHALL have port tile_in  input  16*DW  4x4 transformed input tile, element i = m[r*4+c] at bits [i*DW +: DW].
REQ-010 SHALL have port filt_in  input  16*W  4x4 transformed filter, same packing, element width W.
REQ-011 SHALL have port out_valid  output  1  2x2 result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port out_data  output  4*OW  order y00,y01,y10,y11 at indices 0..3.
REQ-014 SHALL have port beat_cnt  output  8  accepted beats in the current or held group, saturating at 255.

Function
REQ-015 SHALL treat all element arithmetic as signed two's complement with sign extension.
REQ-016 SHALL register p[i] = tile_in[i]*filt_in[i] (DW+W bits) on each accepted beat, with a product-valid flag.
REQ-017 SHALL load acc[i] = p[i] on the edge after the first beat of a group is accepted, and add acc[i] += p[i] for each subsequent beat; accumulation wraps modulo 2^ACCW.
REQ-018 SHALL implement states ACC, DRAIN, XF1, XF2, OUT; in_ready = 1 only in ACC.
REQ-019 ACC: non-last beats are accepted back-to-back at 1 beat/cycle; accepting a beat with in_last=1 moves the block to DRAIN.
REQ-020 DRAIN: folds the last product into acc, then moves to XF1.
REQ-021 XF1: registers t[0][c] = m0c+m1c+m2c and t[1][c] = m1c-m2c-m3c for c=0..3, using acc as m; then moves to XF2.
REQ-022 XF2: registers y[r][0] = t[r][0]+t[r][1]+t[r][2] and y[r][1] = t[r][1]-t[r][2]-t[r][3] into out_data at full OW precision with no wrap; sets out_valid=1; moves to OUT.
REQ-023 out_valid SHALL rise exactly 3 edges after the edge that accepted the in_last beat.
REQ-024 OUT: out_data and out_valid SHALL hold stable while out_ready=0.
REQ-025 OUT: on out_valid && out_ready, out_valid clears on that edge, state returns to ACC, the next accepted beat starts a new group, and beat_cnt restarts at 1 on that beat.
REQ-026 in_last SHALL be sampled only on accepted beats; in_valid and in_last outside ACC SHALL be ignored.
REQ-027 A group of one beat (in_last on the first beat) SHALL be legal and yield the transform of that single product tile.

Reset
REQ-028 While rstn=0: state=ACC, in_ready=1, out_valid=0, out_data=0, beat_cnt=0; all product, accumulator and transform registers=0; product-valid cleared; first-beat flag set.
REQ-029 Reset asserted mid-group or mid-transform SHALL discard all partial state; the first group after reset SHALL carry no residue.

Verification
REQ-030 One beat, tile all 1, filter all 1, in_last=1 -> out_data={9,-3,-3,1}, out_valid 3 cycles after acceptance, beat_cnt=1.
REQ-031 Two back-to-back beats (tile 2/filter 3, then tile -1/filter 4 with in_last) -> M all 2 -> out_data={18,-6,-6,2}, beat_cnt=2.
REQ-032 Impulse: tile 1 only at index 5, filter all 1, single beat -> out_data={1,1,1,1}.
REQ-033 Hold out_ready=0 for 5 cycles with in_valid=1 -> out_data stable, in_ready=0, no beat accepted; release -> handshake, then in_ready=1.
REQ-034 Accept 2 non-last beats, pulse rstn low, then send a single all-1 beat with in_last -> {9,-3,-3,1}.
REQ-035 Single beat, tile=-512, filter=-512 everywhere -> M=262144 -> out_data={2359296,-786432,-786432,262144}.
